// File: rtl/uart_pkg.sv
// Shared definitions for the board-to-board move link: receiver and transmitter FSM states and counter sizing.
// Latency: not applicable (types, constants and constant functions only).
// Backpressure: not applicable.
package uart_pkg;

    // Receiver frame states; the tx side reuses the same encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GUARD = 3'd4
    } uart_state_t;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default link configuration: 65 MHz core, 9600 baud, 16x oversample.
    localparam int SAMP_PER_BIT_DFLT  = 16;
    localparam int CLK_PER_SAMP_DFLT  = 423;
    localparam int WAITING_COUNT_DFLT = 65_000;

    // Bit-centre sample index and counter widths for the default configuration.
    localparam int MID     = SAMP_PER_BIT_DFLT / 2;
    localparam int TICK_W  = cnt_w(CLK_PER_SAMP_DFLT);
    localparam int SAMP_W  = cnt_w(SAMP_PER_BIT_DFLT);
    localparam int GUARD_W = cnt_w(WAITING_COUNT_DFLT);

endpackage

// File: rtl/baud_sample_tick.sv
// Oversample strobe: one-cycle tick every CLK_PER_SAMP clocks, phase restarted by clear.
// Latency: first tick CLK_PER_SAMP clocks after clear drops.
// Backpressure: none; free-running while clear is low.
module baud_sample_tick
    import uart_pkg::*;
#(
    parameter int CLK_PER_SAMP = 423
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear,
    output logic tick
);

    localparam int W = cnt_w(CLK_PER_SAMP);
    localparam logic [W-1:0] CNT_LAST = W'(CLK_PER_SAMP - 1);

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_LAST) && !clear;

    // Count 0..CLK_PER_SAMP-1 and wrap on the tick; clear pins the phase to zero.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_move_rx.sv
// 8N1 move-packet receiver: oversampled, 3-sample majority vote per bit, stop-bit check, post-frame guard.
// Latency: ready/frame_err rise one clock after the edge that takes the last stop-bit centre sample.
// Backpressure: none; ready is a one-cycle pulse and data_out holds until the next good frame.
module uart_move_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ        = 65_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int SAMP_PER_BIT  = 16,
    parameter int CLK_PER_SAMP  = CLK_HZ / BAUD_RATE / SAMP_PER_BIT,
    parameter int PKT_LEN       = 8,
    parameter int WAITING_COUNT = 65_000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rx,
    output logic               ready,
    output logic [PKT_LEN-1:0] data_out,
    output logic               frame_err,
    output logic               busy
);

    localparam int S_W = cnt_w(SAMP_PER_BIT);
    localparam int B_W = cnt_w(PKT_LEN);
    localparam int G_W = cnt_w(WAITING_COUNT);

    localparam logic [S_W-1:0] S_C0   = S_W'(SAMP_PER_BIT / 2 - 1);
    localparam logic [S_W-1:0] S_C1   = S_W'(SAMP_PER_BIT / 2);
    localparam logic [S_W-1:0] S_C2   = S_W'(SAMP_PER_BIT / 2 + 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(SAMP_PER_BIT - 1);
    localparam logic [B_W-1:0] B_LAST = B_W'(PKT_LEN - 1);
    localparam logic [G_W-1:0] G_LAST = G_W'(WAITING_COUNT - 1);

    uart_state_t        state_q;
    logic               rx_m_q, rx_s_q;
    logic [S_W-1:0]     s_q;
    logic [B_W-1:0]     b_q;
    logic [G_W-1:0]     guard_q;
    logic [2:0]         cap_q;
    logic               stop_eval_q;
    logic [PKT_LEN-1:0] shreg_q;
    logic [PKT_LEN-1:0] data_q;
    logic               ready_q;
    logic               ferr_q;
    logic               tick;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Tick phase is held at zero while idle so the grid starts at the detected falling edge.
    baud_sample_tick #(
        .CLK_PER_SAMP(CLK_PER_SAMP)
    ) u_tick (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    assign ready     = ready_q;
    assign frame_err = ferr_q;
    assign data_out  = data_q;
    assign busy      = (state_q != IDLE);

    // Line synchroniser, centre-sample capture and the frame FSM.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            rx_m_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            s_q         <= '0;
            b_q         <= '0;
            guard_q     <= '0;
            cap_q       <= '0;
            stop_eval_q <= 1'b0;
            shreg_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            rx_m_q  <= rx;
            rx_s_q  <= rx_m_q;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;

            // Three samples straddling the bit centre feed the majority vote.
            if (tick && (state_q == DATA || state_q == STOP)) begin
                if (s_q == S_C0) cap_q[0] <= rx_s_q;
                if (s_q == S_C1) cap_q[1] <= rx_s_q;
                if (s_q == S_C2) cap_q[2] <= rx_s_q;
            end

            case (state_q)
                IDLE: begin
                    s_q         <= '0;
                    b_q         <= '0;
                    guard_q     <= '0;
                    stop_eval_q <= 1'b0;
                    if (!rx_s_q) state_q <= START;
                end
                START: begin
                    // A start bit that is high again at its centre was a glitch.
                    // The grid stays anchored to the falling edge, so restarting s
                    // at the end of the start bit puts s==MID on each data-bit centre.
                    if (tick) begin
                        if (s_q == S_C0 && rx_s_q) begin
                            state_q <= IDLE;
                        end else if (s_q == S_LAST) begin
                            s_q     <= '0;
                            b_q     <= '0;
                            state_q <= DATA;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_q == S_LAST) begin
                            shreg_q[b_q] <= maj3(cap_q);
                            s_q          <= '0;
                            if (b_q == B_LAST) state_q <= STOP;
                            else               b_q     <= b_q + 1'b1;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Decide one clock after the last centre sample is registered.
                    if (stop_eval_q) begin
                        stop_eval_q <= 1'b0;
                        guard_q     <= '0;
                        state_q     <= GUARD;
                        if (maj3(cap_q)) begin
                            data_q  <= shreg_q;
                            ready_q <= 1'b1;
                        end else begin
                            ferr_q  <= 1'b1;
                        end
                    end else if (tick) begin
                        if (s_q == S_C2) stop_eval_q <= 1'b1;
                        s_q <= s_q + 1'b1;
                    end
                end
                GUARD: begin
                    // Only an unbroken run of high clocks re-arms the receiver.
                    if (!rx_s_q) begin
                        guard_q <= '0;
                    end else if (guard_q == G_LAST) begin
                        guard_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        guard_q <= guard_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_move_rx.sv
// Directed bench for uart_move_rx: clean, false-start, bad-stop, glitch, guard and reset-abort frames.
// Latency: bit period 64 clocks (4 clocks/tick, 16 ticks/bit), guard 100 clocks.
// Backpressure: none; pulses are counted by a monitor sampled on the falling edge.
module tb_uart_move_rx;

    localparam int BIT_CLKS = 64;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       rx     = 1'b1;
    logic       ready;
    logic [7:0] data_out;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int ready_tot = 0;
    int ferr_tot  = 0;
    int both_tot  = 0;
    int r0, f0;

    uart_move_rx #(
        .CLK_HZ       (65_000_000),
        .BAUD_RATE    (9600),
        .SAMP_PER_BIT (16),
        .CLK_PER_SAMP (4),
        .PKT_LEN      (8),
        .WAITING_COUNT(100)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rx       (rx),
        .ready    (ready),
        .data_out (data_out),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    // Pulse monitor: each high cycle counts, so a stretched pulse shows up as an extra count.
    always @(negedge clk_in) begin
        if (ready)              ready_tot <= ready_tot + 1;
        if (frame_err)          ferr_tot  <= ferr_tot + 1;
        if (ready && frame_err) both_tot  <= both_tot + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Drive nbits bit periods of a frame (start, 8 data LSB first, stop).
    // glitch_bit >= 0 inverts rx for one clock near the centre of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input int glitch_bit, input int nbits);
        logic [9:0] bits;
        bits = {stop_v, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < BIT_CLKS; c++) begin
                @(negedge clk_in);
                rx = bits[i] ^ ((i == glitch_bit + 1) && (c == 36));
            end
        end
        @(negedge clk_in);
        rx = 1'b1;
    endtask

    initial begin
        // Reset
        idle(4);
        check_eq("rst_ready", {31'd0, ready}, 32'd0);
        check_eq("rst_ferr",  {31'd0, frame_err}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_data",  {24'd0, data_out}, 32'd0);
        rst_in = 1'b0;
        idle(10);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        // 1: clean 0xA5
        r0 = ready_tot; f0 = ferr_tot;
        send_frame(8'hA5, 1'b1, -1, 10);
        check_eq("t1_busy_guard", {31'd0, busy}, 32'd1);
        idle(150);
        check_eq("t1_ready_cnt", ready_tot - r0, 32'd1);
        check_eq("t1_ferr_cnt",  ferr_tot - f0, 32'd0);
        check_eq("t1_data",      {24'd0, data_out}, 32'hA5);
        check_eq("t1_busy_end",  {31'd0, busy}, 32'd0);

        // 2: false start, then 0x3C
        r0 = ready_tot; f0 = ferr_tot;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(60);
        check_eq("t2_fs_busy",  {31'd0, busy}, 32'd0);
        check_eq("t2_fs_ready", ready_tot - r0, 32'd0);
        check_eq("t2_fs_ferr",  ferr_tot - f0, 32'd0);
        send_frame(8'h3C, 1'b1, -1, 10);
        idle(150);
        check_eq("t2_ready_cnt", ready_tot - r0, 32'd1);
        check_eq("t2_data",      {24'd0, data_out}, 32'h3C);

        // 3: bad stop on 0x5A; data keeps 0x3C (last good frame)
        r0 = ready_tot; f0 = ferr_tot;
        send_frame(8'h5A, 1'b0, -1, 10);
        idle(60);
        check_eq("t3_busy_mid",  {31'd0, busy}, 32'd1);
        check_eq("t3_ferr_cnt",  ferr_tot - f0, 32'd1);
        check_eq("t3_ready_cnt", ready_tot - r0, 32'd0);
        check_eq("t3_data_kept", {24'd0, data_out}, 32'h3C);
        idle(70);
        check_eq("t3_busy_end",  {31'd0, busy}, 32'd0);

        // 4: one-clock glitch at centre of bit 3 of 0xFF
        r0 = ready_tot;
        send_frame(8'hFF, 1'b1, 3, 10);
        idle(150);
        check_eq("t4_ready_cnt", ready_tot - r0, 32'd1);
        check_eq("t4_data",      {24'd0, data_out}, 32'hFF);

        // 5: 0x01 then 0x80 after only 50 idle clocks; second frame falls in guard
        r0 = ready_tot; f0 = ferr_tot;
        send_frame(8'h01, 1'b1, -1, 10);
        idle(50);
        check_eq("t5_first_data", {24'd0, data_out}, 32'h01);
        send_frame(8'h80, 1'b1, -1, 10);
        idle(150);
        check_eq("t5_ready_cnt", ready_tot - r0, 32'd1);
        check_eq("t5_ferr_cnt",  ferr_tot - f0, 32'd0);
        check_eq("t5_data",      {24'd0, data_out}, 32'h01);
        check_eq("t5_busy_end",  {31'd0, busy}, 32'd0);

        // 6: reset mid-DATA, then 0x77
        r0 = ready_tot; f0 = ferr_tot;
        send_frame(8'h77, 1'b1, -1, 4);
        check_eq("t6_busy_pre", {31'd0, busy}, 32'd1);
        rst_in = 1'b1;
        idle(1);
        rst_in = 1'b0;
        check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_rst_data", {24'd0, data_out}, 32'd0);
        idle(400);
        check_eq("t6_abort_ready", ready_tot - r0, 32'd0);
        check_eq("t6_abort_ferr",  ferr_tot - f0, 32'd0);
        send_frame(8'h77, 1'b1, -1, 10);
        idle(150);
        check_eq("t6_ready_cnt", ready_tot - r0, 32'd1);
        check_eq("t6_data",      {24'd0, data_out}, 32'h77);

        check_eq("never_both", both_tot, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
